// File: rtl/inst_issuer.sv
// Instruction issuer: a small FIFO feeding a processor one instruction at a time,
// with a fixed idle gap after every issue and a hold while the processor stalls.
package inst_issuer_pkg;
    typedef enum logic [2:0] {
        OP_LD, OP_OUT, OP_ADD, OP_SUB, OP_NAND, OP_NOR, OP_XOR, OP_SHFL
    } t_opcode;
    typedef enum logic [2:0] {R0, R1, R2, R3, IMM} t_reg_name;
endpackage

module inst_issuer
    import inst_issuer_pkg::*;
#(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int IMM_W = 8,
    parameter int GAP   = 3    // >= 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  t_opcode          in_opcode,
    input  t_reg_name        in_src1,
    input  t_reg_name        in_src2,
    input  logic [IMM_W-1:0] in_imm,
    output t_opcode          opcode,
    output t_reg_name        src1,
    output t_reg_name        src2,
    output logic [IMM_W-1:0] imm,
    output logic             instv,
    input  logic             stalled,
    input  logic             dataoutv,
    input  logic [IMM_W-1:0] dataout,
    output logic [IMM_W-1:0] res_data,
    output logic             res_valid,
    output logic [7:0]       issued_cnt,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef struct packed {
        t_opcode          op;
        t_reg_name        s1;
        t_reg_name        s2;
        logic [IMM_W-1:0] imm;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_HOLD} state_t;

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             full, empty, push, pop, decide;

    state_t           state_q;
    logic [GW-1:0]    gcnt_q;
    t_opcode          opcode_q;
    t_reg_name        src1_q, src2_q;
    logic [IMM_W-1:0] imm_q;
    logic             instv_q;
    logic [7:0]       issued_cnt_q;
    logic [IMM_W-1:0] res_data_q;
    logic             res_valid_q;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    // Points where the FSM may take the next instruction: idle, end of gap, or stall released.
    always_comb begin
        decide = 1'b0;
        case (state_q)
            S_IDLE:  decide = 1'b1;
            S_GAP:   decide = (gcnt_q == '0) && !stalled;
            S_HOLD:  decide = !stalled;
            default: decide = 1'b0;
        endcase
    end
    assign pop = decide && !empty;

    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q] <= '{op: in_opcode, s1: in_src1, s2: in_src2, imm: in_imm};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gcnt_q       <= '0;
            opcode_q     <= OP_LD;
            src1_q       <= R0;
            src2_q       <= R0;
            imm_q        <= '0;
            instv_q      <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            instv_q <= 1'b0;
            if (pop) begin
                opcode_q     <= mem_q[rptr_q].op;
                src1_q       <= mem_q[rptr_q].s1;
                src2_q       <= mem_q[rptr_q].s2;
                imm_q        <= mem_q[rptr_q].imm;
                instv_q      <= 1'b1;
                issued_cnt_q <= issued_cnt_q + 8'd1;
                state_q      <= S_ISSUE;
            end else begin
                case (state_q)
                    S_ISSUE: begin
                        state_q <= S_GAP;
                        gcnt_q  <= GW'(GAP - 1);
                    end
                    S_GAP: begin
                        if (gcnt_q == '0) state_q <= stalled ? S_HOLD : S_IDLE;
                        else              gcnt_q  <= gcnt_q - 1'b1;
                    end
                    S_HOLD:  if (!stalled) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Result capture runs independently of the issue FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= dataoutv;
            if (dataoutv) res_data_q <= dataout;
        end
    end

    assign opcode     = opcode_q;
    assign src1       = src1_q;
    assign src2       = src2_q;
    assign imm        = imm_q;
    assign instv      = instv_q;
    assign issued_cnt = issued_cnt_q;
    assign res_data   = res_data_q;
    assign res_valid  = res_valid_q;
    assign busy       = (state_q != S_IDLE) || !empty;
endmodule

// File: tb/tb_inst_issuer.sv
// Scoreboard bench for inst_issuer: accepted pushes queue expected instructions,
// every instv pops and compares; issue cycles are logged for spacing checks.
module tb_inst_issuer;
    import inst_issuer_pkg::*;

    localparam int IMM_W = 8;
    typedef logic [9+IMM_W-1:0] ent_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    t_opcode          in_opcode = OP_LD;
    t_reg_name        in_src1 = R0, in_src2 = R0;
    logic [IMM_W-1:0] in_imm = '0;
    t_opcode          opcode;
    t_reg_name        src1, src2;
    logic [IMM_W-1:0] imm;
    logic             instv;
    logic             stalled = 1'b0;
    logic             dataoutv = 1'b0;
    logic [IMM_W-1:0] dataout = '0;
    logic [IMM_W-1:0] res_data;
    logic             res_valid;
    logic [7:0]       issued_cnt;
    logic             busy;

    int   checks = 0, errors = 0, cyc = 0;
    bit   started = 1'b0;
    ent_t exp_q[$];
    int   ic[$];

    inst_issuer #(.DEPTH(4), .IMM_W(IMM_W), .GAP(3)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
        .opcode(opcode), .src1(src1), .src2(src2), .imm(imm), .instv(instv),
        .stalled(stalled), .dataoutv(dataoutv), .dataout(dataout),
        .res_data(res_data), .res_valid(res_valid), .issued_cnt(issued_cnt), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input t_opcode op, input t_reg_name a, input t_reg_name b,
                        input logic [IMM_W-1:0] im, input bit acc);
        in_valid = 1'b1; in_opcode = op; in_src1 = a; in_src2 = b; in_imm = im;
        chk("in_ready", 32'(in_ready), 32'(acc));
        if (acc) exp_q.push_back({op, a, b, im});
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (started && instv) begin
            ic.push_back(cyc);
            if (exp_q.size() == 0) chk("unexp_instv", 32'(1), 32'(0));
            else chk("inst", 32'({opcode, src1, src2, imm}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int t0, s;
        repeat (3) tick();
        reset = 1'b0;
        started = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_instv", 32'(instv), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_res", 32'({res_valid, res_data}), 32'(0));
        chk("rst_cnt", 32'(issued_cnt), 32'(0));
        chk("rst_inst", 32'({opcode, src1, src2, imm}), 32'(0));

        // single instruction latency and idle return
        ic.delete();
        t0 = cyc;
        push(OP_ADD, R1, R2, 8'h11, 1'b1);
        repeat (4) tick();
        chk("busy_gap", 32'(busy), 32'(1));
        tick();
        chk("busy_idle", 32'(busy), 32'(0));
        chk("n_issue1", 32'(ic.size()), 32'(1));
        if (ic.size() > 0) chk("lat1", 32'(ic[0] - t0), 32'(2));
        chk("cnt1", 32'(issued_cnt), 32'(1));

        // fill FIFO behind a stall, drop on full, then spacing after release
        ic.delete();
        stalled = 1'b1;
        t0 = cyc;
        push(OP_LD,   R2, R0,  8'h7E, 1'b1);
        push(OP_OUT,  IMM, R0, 8'h01, 1'b1);
        push(OP_SUB,  R3, IMM, 8'h80, 1'b1);
        push(OP_NAND, R0, R1,  8'hFF, 1'b1);
        push(OP_SHFL, R1, R3,  8'h42, 1'b1);
        push(OP_XOR,  R2, R2,  8'h99, 1'b0);
        repeat (6) tick();
        chk("busy_hold", 32'(busy), 32'(1));
        chk("n_hold", 32'(ic.size()), 32'(1));
        s = cyc;
        stalled = 1'b0;
        repeat (17) tick();
        chk("n_issue2", 32'(ic.size()), 32'(5));
        if (ic.size() == 5) begin
            chk("iss_a", 32'(ic[0] - t0), 32'(2));
            chk("iss_b", 32'(ic[1] - s), 32'(1));
            chk("iss_c", 32'(ic[2] - s), 32'(5));
            chk("iss_d", 32'(ic[3] - s), 32'(9));
            chk("iss_e", 32'(ic[4] - s), 32'(13));
        end
        chk("cnt2", 32'(issued_cnt), 32'(6));
        chk("ready_after", 32'(in_ready), 32'(1));

        // result capture, single and back-to-back
        dataoutv = 1'b1; dataout = 8'hA5;
        tick();
        dataoutv = 1'b0;
        chk("res_a5", 32'({res_valid, res_data}), 32'({1'b1, 8'hA5}));
        tick();
        chk("res_drop", 32'({res_valid, res_data}), 32'({1'b0, 8'hA5}));
        dataoutv = 1'b1; dataout = 8'h3C;
        tick();
        dataout = 8'h5A;
        chk("res_3c", 32'({res_valid, res_data}), 32'({1'b1, 8'h3C}));
        tick();
        dataoutv = 1'b0;
        chk("res_5a", 32'({res_valid, res_data}), 32'({1'b1, 8'h5A}));
        tick();
        chk("res_end", 32'(res_valid), 32'(0));

        // reset during GAP with three queued entries and a coincident push
        ic.delete();
        push(OP_XOR, R3, IMM, 8'h5C, 1'b1);
        push(OP_ADD, R0, R0,  8'h01, 1'b1);
        push(OP_NOR, R1, R1,  8'h02, 1'b1);
        push(OP_SUB, R2, R2,  8'h03, 1'b1);
        reset = 1'b1;
        in_valid = 1'b1; in_opcode = OP_OUT; in_src1 = R1; in_src2 = R0; in_imm = 8'hEE;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("mr_ready", 32'(in_ready), 32'(1));
        chk("mr_busy", 32'(busy), 32'(0));
        chk("mr_cnt", 32'(issued_cnt), 32'(0));
        chk("mr_instv", 32'(instv), 32'(0));
        chk("mr_inst", 32'({opcode, src1, src2, imm}), 32'(0));
        repeat (12) tick();
        chk("mr_n_issue", 32'(ic.size()), 32'(1));

        // 256 issues wrap the counter
        ic.delete();
        for (int i = 0; i < 256; i++) begin
            push(t_opcode'(3'(i)), R0, R1, 8'(i), 1'b1);
            repeat (3) tick();
        end
        repeat (8) tick();
        chk("wrap_n", 32'(ic.size()), 32'(256));
        chk("wrap_cnt", 32'(issued_cnt), 32'(0));
        chk("wrap_busy", 32'(busy), 32'(0));
        chk("exp_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_issuer.md
INST_ISSUER -- requirements
Module: inst_issuer

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, instruction FIFO entries (power of two, at least 2); IMM_W, default 8, immediate/data width; GAP, default 3, enforced idle cycles after each issue.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  host offers an instruction
- in_ready  out  1  FIFO not full; push occurs when in_valid&&in_ready
- in_opcode  in  t_opcode (3)  LD/OUT/ADD/SUB/NAND/NOR/XOR/SHFL
- in_src1, in_src2  in  t_reg_name (3)  R0-R3 or IMM
- in_imm  in  IMM_W  immediate value
- opcode  out  t_opcode  to processor
- src1, src2  out  t_reg_name  to processor
- imm  out  IMM_W  to processor
- instv  out  1  instruction valid to processor
- stalled  in  1  processor stall indication
- dataoutv  in  1  processor OUT result valid
- dataout  in  IMM_W  processor OUT result
- res_data  out  IMM_W  last captured result
- res_valid  out  1  one-cycle pulse on capture
- issued_cnt  out  8  instructions issued, wraps 255->0
- busy  out  1  FIFO non-empty or state not IDLE
REQ-003 Reset SHALL be: reset reset, synchronous, active-high; clock clock.

Function
REQ-004 The FIFO SHALL be DEPTH-entry, first-in first-out, with one push and one pop allowed in the same cycle.
REQ-005 in_ready SHALL equal !full and be combinational from FIFO occupancy only.
REQ-006 When in_valid=1 and full, the push SHALL be dropped with no state change.
REQ-007 Pointers SHALL wrap modulo DEPTH; occupancy SHALL use a count that is one bit wider than the pointers.
REQ-008 The FSM SHALL have four states: IDLE, ISSUE, GAP, HOLD.
REQ-009 IDLE transition: if FIFO non-empty, pop the head into the opcode/src1/src2/imm registers and go to ISSUE; otherwise stay in IDLE.
REQ-010 In ISSUE, instv SHALL be 1 for exactly one cycle and issued_cnt SHALL increment; the next state SHALL be GAP with gap counter = GAP-1.
REQ-011 In GAP, instv SHALL be 0 and the counter SHALL decrement each cycle.
REQ-012 On the final GAP cycle (counter=0), exit SHALL be:
- stalled=1: go to HOLD
- else FIFO non-empty: pop and go to ISSUE
- else: go to IDLE
REQ-013 In HOLD, instv SHALL be 0; when stalled=0, apply the same pop/ISSUE or IDLE decision as REQ-012.
REQ-014 With a non-empty FIFO and stalled low after the GAP window, issue spacing SHALL be exactly GAP+1 cycles (4 by default).
REQ-015 opcode/src1/src2/imm SHALL hold their values outside ISSUE; only instv qualifies them.
REQ-016 Illegal combinations (LD with a GPR, OUT with IMM) SHALL be issued unchanged, because filtering is the processor's job.
REQ-017 On any cycle with dataoutv=1, res_data<=dataout and res_valid SHALL pulse the next cycle, independent of FSM state.
REQ-018 Back-to-back dataoutv cycles SHALL each produce a capture, with the last value winning.
REQ-019 busy SHALL be 0 only when state=IDLE and the FIFO is empty.

Reset
REQ-020 On reset, the following SHALL occur on the next edge:
- FIFO emptied (in_ready=1)
- state=IDLE
- instv=0, res_valid=0, busy=0
- res_data=0, issued_cnt=0
- opcode/src1/src2/imm=0
REQ-021 A reset asserted mid-ISSUE/GAP/HOLD SHALL abort immediately, discarding queued entries; no instv SHALL appear during reset.
REQ-022 A push coinciding with reset SHALL be discarded.

Verification
REQ-023 Push ADD R1,R2 at cycle 0 with stalled low -> instv=1 at cycle 2 only, issued_cnt=1, busy=0 at cycle 6.
REQ-024 Push 4 instructions back-to-back -> in_ready=0 after the 4th push (with no pop yet), a 5th push is dropped, and issues occur at cycles t, t+4, t+8, t+12.
REQ-025 Hold stalled=1 for 6 cycles after an issue -> FSM sits in HOLD, no instv until 1 cycle after stalled falls.
REQ-026 Pulse dataoutv=1 with dataout=0xA5 -> res_data=0xA5, res_valid=1 for one cycle.
REQ-027 Assert reset during GAP with 3 queued entries -> in_ready=1, busy=0, issued_cnt=0, and no instv afterwards until a new push.
REQ-028 Issue 256 instructions -> issued_cnt wraps to 0.
